// File: rtl/branch_cond_pkg.sv
// Shared definitions for the branch condition unit: condition codes and FSM states.
package branch_cond_pkg;

  localparam int unsigned COND_W = 3;

  typedef enum logic [COND_W-1:0] {
    COND_EQ     = 3'b000,
    COND_NE     = 3'b001,
    COND_GE     = 3'b010,
    COND_LT     = 3'b011,
    COND_GT     = 3'b100,
    COND_LE     = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_WAIT_B = 1'b1
  } state_e;

endpackage

// File: rtl/branch_cond_if.sv
// Control/datapath signals of the branch condition unit; master drives, slave evaluates.
interface branch_cond_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned HIST_D = 4
);
  logic              con_in;
  logic [DATA_W-1:0] bus_in;
  logic [2:0]        ir_cond;
  logic              cmp_mode;
  logic              signed_cmp;
  logic              cancel;
  logic              taken_ack;
  logic              con_out;
  logic              con_valid;
  logic              busy;
  logic [HIST_D-1:0] con_hist;

  modport master (
    output con_in, bus_in, ir_cond, cmp_mode, signed_cmp, cancel, taken_ack,
    input  con_out, con_valid, busy, con_hist
  );

  modport slave (
    input  con_in, bus_in, ir_cond, cmp_mode, signed_cmp, cancel, taken_ack,
    output con_out, con_valid, busy, con_hist
  );
endinterface

// File: rtl/cond_compare.sv
// Combinational evaluation of one condition code on operands x and y.
module cond_compare
  import branch_cond_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  cond_e             cond_i,
  input  logic              is_signed_i,
  output logic              result_o
);

  logic eq;
  logic lt;

  assign eq = (x_i == y_i);
  assign lt = is_signed_i ? ($signed(x_i) < $signed(y_i)) : (x_i < y_i);

  always_comb begin
    result_o = 1'b0;
    case (cond_i)
      COND_EQ:     result_o = eq;
      COND_NE:     result_o = !eq;
      COND_GE:     result_o = !lt;
      COND_LT:     result_o = lt;
      COND_GT:     result_o = !lt && !eq;
      COND_LE:     result_o = lt || eq;
      COND_ALWAYS: result_o = 1'b1;
      COND_NEVER:  result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: zero or two-operand compare, registered result, valid flag and history.
module branch_cond_unit
  import branch_cond_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned HIST_D = 4
) (
  input  logic         clk,
  input  logic         clr,
  branch_cond_if.slave bus
);

  state_e            state_q;
  logic [DATA_W-1:0] a_q;
  logic              con_out_q;
  logic              con_valid_q;
  logic [HIST_D-1:0] hist_q;

  logic [DATA_W-1:0] cmp_x;
  logic [DATA_W-1:0] cmp_y;
  logic              cmp_res;
  logic [HIST_D-1:0] hist_d;
  logic              in_wait;

  // In WAIT_B the captured operand is X and the bus is Y; otherwise compare the bus against zero.
  assign in_wait = (state_q == ST_WAIT_B);
  assign cmp_x   = in_wait ? a_q : bus.bus_in;
  assign cmp_y   = in_wait ? bus.bus_in : '0;
  assign hist_d  = (hist_q << 1) | HIST_D'(cmp_res);

  cond_compare #(.DATA_W(DATA_W)) u_cmp (
    .x_i         (cmp_x),
    .y_i         (cmp_y),
    .cond_i      (cond_e'(bus.ir_cond)),
    .is_signed_i (bus.signed_cmp),
    .result_o    (cmp_res)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      con_out_q   <= 1'b0;
      con_valid_q <= 1'b0;
      hist_q      <= '0;
    end else begin
      // Acknowledge first so a same-cycle evaluation overrides it.
      if (bus.taken_ack) con_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.con_in) begin
            if (bus.cmp_mode) begin
              a_q     <= bus.bus_in;
              state_q <= ST_WAIT_B;
            end else begin
              con_out_q   <= cmp_res;
              con_valid_q <= 1'b1;
              hist_q      <= hist_d;
            end
          end
        end
        ST_WAIT_B: begin
          if (bus.cancel) begin
            state_q <= ST_IDLE;
          end else if (bus.con_in) begin
            con_out_q   <= cmp_res;
            con_valid_q <= 1'b1;
            hist_q      <= hist_d;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.con_out   = con_out_q;
  assign bus.con_valid = con_valid_q;
  assign bus.busy      = in_wait;
  assign bus.con_hist  = hist_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_cond_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned HD = 4;

  logic clk;
  logic clr;
  int   checks;
  int   failures;
  bit   chk_en;

  branch_cond_if #(.DATA_W(DW), .HIST_D(HD)) bif ();

  branch_cond_unit #(.DATA_W(DW), .HIST_D(HD)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  bit          m_busy;
  logic [31:0] m_a;
  bit          m_out;
  bit          m_valid;
  logic [3:0]  m_hist;

  function automatic bit model_cond(input logic [2:0] c, input logic [31:0] x,
                                    input logic [31:0] y, input bit s);
    longint xv;
    longint yv;
    xv = s ? longint'({{32{x[31]}}, x}) : longint'({32'b0, x});
    yv = s ? longint'({{32{y[31]}}, y}) : longint'({32'b0, y});
    case (c)
      3'd0:    return xv == yv;
      3'd1:    return xv != yv;
      3'd2:    return xv >= yv;
      3'd3:    return xv <  yv;
      3'd4:    return xv >  yv;
      3'd5:    return xv <= yv;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge clr) begin : model
    bit ev;
    bit r;
    ev = 1'b0;
    r  = 1'b0;
    if (clr) begin
      m_busy  <= 1'b0;
      m_a     <= '0;
      m_out   <= 1'b0;
      m_valid <= 1'b0;
      m_hist  <= '0;
    end else begin
      if (m_busy) begin
        if (bif.cancel) m_busy <= 1'b0;
        else if (bif.con_in) begin
          ev = 1'b1;
          r  = model_cond(bif.ir_cond, m_a, bif.bus_in, bif.signed_cmp);
          m_busy <= 1'b0;
        end
      end else if (bif.con_in) begin
        if (bif.cmp_mode) begin
          m_a    <= bif.bus_in;
          m_busy <= 1'b1;
        end else begin
          ev = 1'b1;
          r  = model_cond(bif.ir_cond, bif.bus_in, 32'd0, bif.signed_cmp);
        end
      end
      if (ev) begin
        m_out   <= r;
        m_valid <= 1'b1;
        m_hist  <= {m_hist[2:0], r};
      end else if (bif.taken_ack) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.busy",  32'(bif.busy),      32'(m_busy));
      chk("model.out",   32'(bif.con_out),   32'(m_out));
      chk("model.valid", 32'(bif.con_valid), 32'(m_valid));
      chk("model.hist",  32'(bif.con_hist),  32'(m_hist));
    end
  end

  task automatic drive(input bit cin, input logic [31:0] b, input logic [2:0] c,
                       input bit mode, input bit s, input bit canc = 1'b0, input bit ack = 1'b0);
    bif.con_in     = cin;
    bif.bus_in     = b;
    bif.ir_cond    = c;
    bif.cmp_mode   = mode;
    bif.signed_cmp = s;
    bif.cancel     = canc;
    bif.taken_ack  = ack;
    @(posedge clk);
    #1;
    bif.con_in    = 1'b0;
    bif.cancel    = 1'b0;
    bif.taken_ack = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    clr      = 1'b1;
    bif.con_in = 1'b0; bif.bus_in = '0; bif.ir_cond = '0; bif.cmp_mode = 1'b0;
    bif.signed_cmp = 1'b0; bif.cancel = 1'b0; bif.taken_ack = 1'b0;
    #1;
    chk("rst.busy",  32'(bif.busy),      32'd0);
    chk("rst.out",   32'(bif.con_out),   32'd0);
    chk("rst.valid", 32'(bif.con_valid), 32'd0);
    chk("rst.hist",  32'(bif.con_hist),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    clr    = 1'b0;
    chk_en = 1'b1;

    // Async clear during WAIT_B with a result pending
    drive(1, 32'h0, 3'd6, 0, 0);
    chk("pre.out", 32'(bif.con_out), 32'd1);
    drive(1, 32'h1234, 3'd0, 1, 0);
    chk("pre.busy", 32'(bif.busy), 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("clr.busy",  32'(bif.busy),      32'd0);
    chk("clr.out",   32'(bif.con_out),   32'd0);
    chk("clr.valid", 32'(bif.con_valid), 32'd0);
    chk("clr.hist",  32'(bif.con_hist),  32'd0);
    clr = 1'b0;
    @(posedge clk); #1;

    // Zero mode
    drive(1, 32'h0, 3'd0, 0, 0);
    chk("zeq.out",   32'(bif.con_out),   32'd1);
    chk("zeq.valid", 32'(bif.con_valid), 32'd1);
    chk("zeq.busy",  32'(bif.busy),      32'd0);
    drive(1, 32'h8000_0000, 3'd3, 0, 1);
    chk("zlt_s.out", 32'(bif.con_out), 32'd1);
    drive(1, 32'h8000_0000, 3'd3, 0, 0);
    chk("zlt_u.out", 32'(bif.con_out), 32'd0);

    // Two-operand compare; cmp_mode ignored in WAIT_B
    drive(1, 32'hFFFF_FFFF, 3'd4, 1, 1);
    chk("gt_s.busy_a", 32'(bif.busy),    32'd1);
    chk("gt_s.held",   32'(bif.con_out), 32'd0);
    drive(1, 32'h1, 3'd4, 0, 1);
    chk("gt_s.out",    32'(bif.con_out), 32'd0);
    chk("gt_s.busy_b", 32'(bif.busy),    32'd0);
    drive(1, 32'hFFFF_FFFF, 3'd4, 1, 0);
    drive(1, 32'h1, 3'd4, 1, 0);
    chk("gt_u.out",  32'(bif.con_out),  32'd1);
    chk("gt_u.busy", 32'(bif.busy),     32'd0);
    chk("gt_u.hist", 32'(bif.con_hist), 32'b1001);

    // Cancel has priority over con_in; no effect in IDLE
    drive(1, 32'd5, 3'd0, 1, 0);
    chk("cancel.busy_a", 32'(bif.busy), 32'd1);
    drive(1, 32'd5, 3'd0, 1, 0, 1);
    chk("cancel.busy",  32'(bif.busy),      32'd0);
    chk("cancel.out",   32'(bif.con_out),   32'd1);
    chk("cancel.valid", 32'(bif.con_valid), 32'd1);
    chk("cancel.hist",  32'(bif.con_hist),  32'b1001);
    drive(0, 32'd0, 3'd0, 0, 0, 1);
    chk("cancel_idle.busy", 32'(bif.busy), 32'd0);

    // History
    drive(1, 32'd0, 3'd6, 0, 0);
    drive(1, 32'd0, 3'd7, 0, 0);
    drive(1, 32'd0, 3'd6, 0, 0);
    drive(1, 32'd0, 3'd6, 0, 0);
    drive(1, 32'd0, 3'd7, 0, 0);
    chk("hist.val", 32'(bif.con_hist), 32'b0110);
    chk("hist.out", 32'(bif.con_out),  32'd0);

    // Acknowledge
    drive(1, 32'd0, 3'd6, 0, 0, 0, 1);
    chk("ack_ev.valid", 32'(bif.con_valid), 32'd1);
    chk("ack_ev.out",   32'(bif.con_out),   32'd1);
    drive(0, 32'd0, 3'd0, 0, 0, 0, 1);
    chk("ack.valid", 32'(bif.con_valid), 32'd0);
    chk("ack.out",   32'(bif.con_out),   32'd1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 3));
        1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
        2:       b = 32'h8000_0000 + 32'($urandom_range(0, 1));
        default: b = $urandom();
      endcase
      clr = ($urandom_range(0, 39) == 0);
      drive(bit'($urandom_range(0, 1)), b, 3'($urandom_range(0, 7)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      clr = 1'b0;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the bus operand.
REQ-002 SHALL have parameter HIST_D, default 4: depth of the branch-outcome history register (>=1).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port clr, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port con_in, input, 1: evaluate/capture strobe from the control unit.
REQ-006 SHALL have port bus_in, input, DATA_W: operand taken from the datapath bus.
REQ-007 SHALL have port ir_cond, input, 3: condition code from the instruction register.
REQ-008 SHALL have port cmp_mode, input, 1: 0 = compare bus_in against zero; 1 = two-operand compare.
REQ-009 SHALL have port signed_cmp, input, 1: 1 = two's-complement compare; 0 = unsigned compare.
REQ-010 SHALL have port cancel, input, 1: abandon a pending two-operand compare.
REQ-011 SHALL have port taken_ack, input, 1: consumer acknowledges con_out; clears con_valid.
REQ-012 SHALL have port con_out, output, 1: registered branch-taken result.
REQ-013 SHALL have port con_valid, output, 1: con_out holds an unconsumed result.
REQ-014 SHALL have port busy, output, 1: operand A captured; waiting for operand B.
REQ-015 SHALL have port con_hist, output, HIST_D: the last HIST_D results; bit 0 is the newest.

Function
REQ-016 SHALL decode ir_cond as follows: 000 EQ, 001 NE, 010 GE, 011 LT, 100 GT, 101 LE, 110 ALWAYS, 111 NEVER.
REQ-017 SHALL compare X against Y using the decoded condition; in zero mode X = bus_in and Y = 0; in two-operand mode X = captured A and Y = bus_in.
REQ-018 SHALL follow signed_cmp for every comparison; unsigned GE against zero is always true and unsigned LT against zero is always false.
REQ-019 SHALL use an FSM with two states, IDLE and WAIT_B; busy SHALL equal (state == WAIT_B).
REQ-020 In IDLE, con_in=1 with cmp_mode=0 SHALL evaluate in that cycle, load con_out, set con_valid and stay in IDLE.
REQ-021 In IDLE, con_in=1 with cmp_mode=1 SHALL capture bus_in into A, go to WAIT_B, and leave con_out, con_valid and con_hist unchanged.
REQ-022 In WAIT_B, con_in=1 SHALL evaluate A against bus_in, using ir_cond and signed_cmp as sampled in that cycle, load con_out, set con_valid and return to IDLE; cmp_mode SHALL be ignored in WAIT_B.
REQ-023 In WAIT_B, cancel=1 SHALL return the FSM to IDLE with no result and no history update; cancel SHALL take priority over con_in.
REQ-024 cancel in IDLE SHALL have no effect.
REQ-025 Latency: con_out and con_valid SHALL change on the clock edge that samples the evaluating con_in, i.e. they are visible one cycle after the strobe.
REQ-026 Each evaluation SHALL shift its result into con_hist bit 0, discarding the oldest bit.
REQ-027 taken_ack=1 SHALL clear con_valid on the next edge; con_out SHALL hold its value until the next evaluation.
REQ-028 If taken_ack and an evaluation occur in the same cycle, the new result SHALL win and con_valid SHALL remain 1.
REQ-029 Evaluating while con_valid=1 SHALL overwrite con_out without error.

Reset
REQ-030 clr=1 SHALL immediately force the state to IDLE, A to 0, con_out to 0, con_valid to 0, busy to 0 and con_hist to all zeros, independent of clk.
REQ-031 clr asserted during WAIT_B SHALL discard the captured operand; the first con_in after release SHALL be treated as an IDLE strobe.

Structure
REQ-032 The condition-code constants (EQ..NEVER) and the FSM state encoding SHALL be defined in a shared package, branch_cond_pkg.
REQ-033 The comparison SHALL be implemented in one combinational sub-module, cond_compare (parameter DATA_W; inputs X, Y, cond, signed; output result), instantiated once.

Verification
REQ-034 clr pulse mid-operation -> all outputs 0 and state IDLE immediately, without waiting for a clk edge.
REQ-035 Zero mode, bus_in=0x00000000, ir_cond=EQ, con_in -> next cycle con_out=1 and con_valid=1; then bus_in=0x80000000, ir_cond=LT, signed -> con_out=1; the same stimulus unsigned -> con_out=0.
REQ-036 Two-operand signed: A=0xFFFFFFFF, B=0x00000001, GT -> con_out=0; the same operands unsigned -> con_out=1; busy=1 only between the two strobes.
REQ-037 Capture A=5, assert cancel together with con_in -> state IDLE, con_out, con_valid and con_hist unchanged.
REQ-038 Five evaluations ALWAYS, NEVER, ALWAYS, ALWAYS, NEVER with HIST_D=4 -> con_hist=4'b0110.
REQ-039 taken_ack coincident with an evaluation -> con_valid stays 1; taken_ack alone on the next cycle -> con_valid=0 and con_out held.
